// File: rtl/pipe_reg_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_reg_skid                                                            |
// | DEPTH-stage valid/ready pipeline register with a skid slot per stage.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipe_reg_skid #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]   level
);

  localparam int c_lw = $clog2(2*DEPTH+1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  logic             w_vld    [DEPTH];
  logic             w_rdy_up [DEPTH];
  logic [WIDTH-1:0] w_main   [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    state_t           r_state;
    state_t           w_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_vld_in;
    logic [WIDTH-1:0] w_din;
    logic             w_rdy_dn;
    logic             w_push;
    logic             w_pop;
    logic             w_ld_main;
    logic             w_ld_skid;
    logic             w_main_from_skid;

    if (k == 0) begin : g_first
      assign w_vld_in = in_valid;
      assign w_din    = in_data;
    end else begin : g_chain
      assign w_vld_in = w_vld[k-1];
      assign w_din    = w_main[k-1];
    end

    if (k == DEPTH - 1) begin : g_last
      assign w_rdy_dn = out_ready;
    end else begin : g_mid
      assign w_rdy_dn = w_rdy_up[k+1];
    end

    // Both handshake qualifiers come straight from state registers.
    assign w_vld[k]    = (r_state != ST_EMPTY);
    assign w_rdy_up[k] = (r_state != ST_TWO);
    assign w_main[k]   = r_main;
    assign w_push      = w_vld_in & w_rdy_up[k];
    assign w_pop       = w_vld[k] & w_rdy_dn;

    always_comb begin
      w_nxt            = r_state;
      w_ld_main        = 1'b0;
      w_ld_skid        = 1'b0;
      w_main_from_skid = 1'b0;
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_nxt     = ST_ONE;
            w_ld_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && !w_pop) begin
            w_nxt     = ST_TWO;
            w_ld_skid = 1'b1;
          end else if (w_pop && !w_push) begin
            w_nxt = ST_EMPTY;
          end else if (w_push && w_pop) begin
            w_ld_main = 1'b1;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_nxt            = ST_ONE;
            w_ld_main        = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_nxt = ST_EMPTY;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= ST_EMPTY;
        r_main  <= RESET_VAL;
        r_skid  <= RESET_VAL;
      end else if (flush) begin
        r_state <= ST_EMPTY;
        r_main  <= RESET_VAL;
        r_skid  <= RESET_VAL;
      end else begin
        r_state <= w_nxt;
        if (w_ld_main) r_main <= w_main_from_skid ? r_skid : w_din;
        if (w_ld_skid) r_skid <= w_din;
      end
    end
  end

  assign in_ready  = w_rdy_up[0];
  assign out_valid = w_vld[DEPTH-1];
  assign out_data  = w_main[DEPTH-1];

  logic w_in_fire;
  logic w_out_fire;
  logic [c_lw-1:0] r_level;

  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= '0;
    end else if (flush) begin
      r_level <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_level <= r_level + c_lw'(1);
    end else if (w_out_fire && !w_in_fire) begin
      r_level <= r_level - c_lw'(1);
    end
  end

  assign level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_reg_skid                                                         |
// | Bench for pipe_reg_skid in three widths/depths against a queue model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipe_reg_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        fl   [3];
  logic        iv   [3];
  logic        ordy [3];
  logic [31:0] idat [3];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar i = 0; i < 3; i++) begin : g_cfg
    localparam int W  = (i == 0) ? 16 : (i == 1) ? 8 : 32;
    localparam int D  = (i == 0) ? 2  : (i == 1) ? 1 : 4;
    localparam int LW = $clog2(2*D+1);

    logic          ir;
    logic          ov;
    logic [W-1:0]  od;
    logic [LW-1:0] lv;

    pipe_reg_skid #(.WIDTH(W), .DEPTH(D)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (fl[i]),
      .in_valid  (iv[i]),
      .in_ready  (ir),
      .in_data   (idat[i][W-1:0]),
      .out_valid (ov),
      .out_ready (ordy[i]),
      .out_data  (od),
      .level     (lv)
    );

    // Model: FIFO of accepted beats; the oldest beat reaches the output
    // D cycles after its push because nothing ahead of it can block it.
    logic [31:0] q  [$];
    int          ts [$];

    always @(negedge clk) begin
      bit ev;
      if (!rst) begin
        q.delete();
        ts.delete();
        chk($sformatf("c%0d_rst_ov", i), 32'(ov), 32'd0);
        chk($sformatf("c%0d_rst_ir", i), 32'(ir), 32'd1);
        chk($sformatf("c%0d_rst_lv", i), 32'(lv), 32'd0);
        chk($sformatf("c%0d_rst_od", i), 32'(od), 32'd0);
      end else begin
        ev = 1'b0;
        if (q.size() != 0) ev = (cyc >= ts[0] + D);
        chk($sformatf("c%0d_ov", i), 32'(ov), 32'(ev));
        if (ev) chk($sformatf("c%0d_od", i), 32'(od), q[0]);
        chk($sformatf("c%0d_level", i), 32'(lv), 32'(q.size()));
        if (q.size() == 2*D) chk($sformatf("c%0d_ir_full", i), 32'(ir), 32'd0);
        if (q.size() == 0)   chk($sformatf("c%0d_ir_empty", i), 32'(ir), 32'd1);
        if (fl[i]) begin
          q.delete();
          ts.delete();
        end else begin
          if (ov && ordy[i] && q.size() != 0) begin
            void'(q.pop_front());
            void'(ts.pop_front());
          end
          if (iv[i] && ir) begin
            q.push_back(32'(idat[i][W-1:0]));
            ts.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      fl[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0; idat[i] = '0;
    end
  endtask

  initial begin
    int  acc;
    bit  seen;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fl[i] = 1'($urandom); iv[i] = 1'($urandom);
      ordy[i] = 1'($urandom); idat[i] = $urandom;
    end
    for (int n = 0; n < 4; n++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        fl[i] = 1'($urandom); iv[i] = 1'($urandom);
        ordy[i] = 1'($urandom); idat[i] = $urandom;
      end
    end
    step();
    idle();
    rst = 1'b1;
    step();

    // Streaming at full rate: first output two cycles after first push.
    ordy[0] = 1'b1;
    for (int j = 0; j < 22; j++) begin
      iv[0]   = (j < 16);
      idat[0] = 32'(j + 1);
      @(negedge clk);
      chk("stream_ov", 32'(g_cfg[0].ov), 32'(j >= 2 && j < 18));
      if (j >= 2 && j < 18) chk("stream_data", 32'(g_cfg[0].od), 32'(j - 1));
      if (j < 16) chk("stream_ir", 32'(g_cfg[0].ir), 32'd1);
      chk("stream_lvl_le2", 32'(g_cfg[0].lv <= 2), 32'd1);
      step();
    end

    // Fill under backpressure then drain in order.
    iv[0] = 1'b0; ordy[0] = 1'b0; acc = 0;
    for (int j = 0; j < 6; j++) begin
      iv[0]   = 1'b1;
      idat[0] = 32'hA000 + 32'(acc);
      @(negedge clk);
      chk("fill_ir", 32'(g_cfg[0].ir), 32'(j < 4));
      if (j == 4) chk("fill_level", 32'(g_cfg[0].lv), 32'd4);
      if (g_cfg[0].ir) acc++;
      step();
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_ov", 32'(g_cfg[0].ov), 32'd1);
      chk("drain_data", 32'(g_cfg[0].od), 32'hA000 + 32'(k));
      step();
    end
    @(negedge clk);
    chk("drain_done_ov", 32'(g_cfg[0].ov), 32'd0);
    chk("drain_done_ir", 32'(g_cfg[0].ir), 32'd1);
    chk("drain_done_lv", 32'(g_cfg[0].lv), 32'd0);
    step();

    // Stall: output held stable while downstream refuses.
    ordy[0] = 1'b0; iv[0] = 1'b1; idat[0] = 32'h5A5A;
    step();
    iv[0] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = g_cfg[0].ov;
    end
    chk("stall_seen", 32'(seen), 32'd1);
    for (int t = 0; t < 5; t++) begin
      chk("stall_ov", 32'(g_cfg[0].ov), 32'd1);
      chk("stall_data", 32'(g_cfg[0].od), 32'h5A5A);
      @(negedge clk);
    end
    step();
    ordy[0] = 1'b1;
    step(); step();
    ordy[0] = 1'b0;

    // Flush with three beats held and a push in the same cycle.
    for (int b = 0; b < 3; b++) begin
      iv[0] = 1'b1; idat[0] = 32'h1111 * 32'(b + 1);
      step();
    end
    iv[0] = 1'b1; idat[0] = 32'hDEAD; fl[0] = 1'b1;
    @(negedge clk);
    chk("flush_pre_level", 32'(g_cfg[0].lv), 32'd3);
    step();
    iv[0] = 1'b0; fl[0] = 1'b0;
    @(negedge clk);
    chk("flush_level", 32'(g_cfg[0].lv), 32'd0);
    chk("flush_ov", 32'(g_cfg[0].ov), 32'd0);
    chk("flush_ir", 32'(g_cfg[0].ir), 32'd1);
    step();
    ordy[0] = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("flush_no_beat", 32'(g_cfg[0].ov), 32'd0);
      step();
    end

    // Random traffic on every configuration, checked by the model.
    for (int n = 0; n < 30000; n++) begin
      for (int i = 0; i < 3; i++) begin
        iv[i]   = ($urandom_range(0, 9) < 7);
        ordy[i] = ($urandom_range(0, 9) < 7);
        idat[i] = $urandom;
        fl[i]   = ($urandom_range(0, 1999) == 0);
      end
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) ordy[i] = 1'b1;
    for (int n = 0; n < 12; n++) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
